// File: rtl/dvi_timing_ctrl.sv
// Video timing controller and RGB555 pixel sequencer for the CH7301C (IDF=3 packing, codec reset).
// Optional: define DVI_UNDERFLOW_COUNT_EN to add a saturating underflow_count output.
module dvi_timing_ctrl #(
    parameter int unsigned H_VISIBLE     = 1024,
    parameter int unsigned H_FRONT       = 24,
    parameter int unsigned H_SYNC        = 136,
    parameter int unsigned H_BACK        = 160,
    parameter int unsigned V_VISIBLE     = 768,
    parameter int unsigned V_FRONT       = 3,
    parameter int unsigned V_SYNC        = 6,
    parameter int unsigned V_BACK        = 29,
    parameter bit          SYNC_POLARITY = 1'b0,
    parameter int unsigned RESET_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic [11:0] dvi_data_b,
    output logic [11:0] dvi_data_a,
    output logic        dvi_de,
    output logic        dvi_h,
    output logic        dvi_v,
`ifdef DVI_UNDERFLOW_COUNT_EN
    output logic [15:0] underflow_count,
`endif
    output logic        dvi_reset_b
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_VIS_END  = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    localparam logic SYNC_ON  = SYNC_POLARITY;
    localparam logic SYNC_OFF = ~SYNC_POLARITY;

    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    logic [10:0]   h;
    logic [9:0]    v;
    logic [RW-1:0] rst_cnt;
    logic          run;
    logic          vis_line;
    logic          active;
    logic          starve;

    // Codec reset: dvi_reset_b rises on the RESET_CYCLES-th edge after rst release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt     <= '0;
            dvi_reset_b <= 1'b0;
        end else if (!dvi_reset_b) begin
            rst_cnt <= rst_cnt + RW'(1);
            if (rst_cnt == RST_LAST)
                dvi_reset_b <= 1'b1;
        end
    end

    always_comb begin
        run       = en & dvi_reset_b;
        vis_line  = (v >= V_VIS_BEG) && (v < V_VIS_END);
        active    = (h >= H_ACT_BEG) && (h < H_ACT_END);
        pix_ready = run & vis_line & active;
        pix_x     = pix_ready ? (h - H_ACT_BEG) : '0;
        pix_y     = pix_ready ? (v - V_VIS_BEG) : '0;
        starve    = pix_ready & ~pix_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!run) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    // Every output is gated by run so an idle controller never shows sync at the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvi_de      <= 1'b0;
            dvi_h       <= SYNC_OFF;
            dvi_v       <= SYNC_OFF;
            dvi_data_b  <= '0;
            dvi_data_a  <= '0;
            frame_start <= 1'b0;
        end else begin
            dvi_de      <= pix_ready;
            dvi_h       <= (run && vis_line && (h < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            dvi_v       <= (run && (v < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            frame_start <= run && (h == '0) && (v == '0);
            if (pix_ready && pix_valid) begin
                dvi_data_b <= {1'b0, pix_data[14:10], pix_data[9:8], 4'b0000};
                dvi_data_a <= {pix_data[7:5], pix_data[4:0], 4'b0000};
            end else begin
                dvi_data_b <= '0;
                dvi_data_a <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underflow <= 1'b0;
        else if (starve)
            underflow <= 1'b1;
        else if (underflow_clr)
            underflow <= 1'b0;
    end

`ifdef DVI_UNDERFLOW_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underflow_count <= '0;
        else if (underflow_clr)
            underflow_count <= starve ? 16'd1 : 16'd0;
        else if (starve && (underflow_count != '1))
            underflow_count <= underflow_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench for dvi_timing_ctrl using a reduced 17x9 raster; second instance covers SYNC_POLARITY=1.
// Honours DVI_UNDERFLOW_COUNT_EN when defined.
module tb_dvi_timing_ctrl;

    localparam int HV = 8, HF = 2, HS = 3, HB = 4;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 17
    localparam int VT = VV + VF + VS + VB;   // 9
    localparam int RC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [14:0] pix_data = 15'h0;
    logic        pix_valid = 1'b1;
    logic        underflow_clr = 1'b0;

    logic        pix_ready, frame_start, underflow, dvi_de, dvi_h, dvi_v, dvi_reset_b;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [11:0] dvi_data_b, dvi_data_a;

    logic        p1_pix_ready, p1_frame_start, p1_underflow, p1_de, p1_h, p1_v, p1_reset_b;
    logic [10:0] p1_pix_x;
    logic [9:0]  p1_pix_y;
    logic [11:0] p1_data_b, p1_data_a;
`ifdef DVI_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_count, p1_underflow_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvi_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(1'b0), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .underflow(underflow), .underflow_clr(underflow_clr),
        .dvi_data_b(dvi_data_b), .dvi_data_a(dvi_data_a), .dvi_de(dvi_de),
        .dvi_h(dvi_h), .dvi_v(dvi_v),
`ifdef DVI_UNDERFLOW_COUNT_EN
        .underflow_count(underflow_count),
`endif
        .dvi_reset_b(dvi_reset_b)
    );

    dvi_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POLARITY(1'b1), .RESET_CYCLES(RC)
    ) dut_p1 (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(p1_pix_ready), .pix_x(p1_pix_x), .pix_y(p1_pix_y), .frame_start(p1_frame_start),
        .underflow(p1_underflow), .underflow_clr(underflow_clr),
        .dvi_data_b(p1_data_b), .dvi_data_a(p1_data_a), .dvi_de(p1_de),
        .dvi_h(p1_h), .dvi_v(p1_v),
`ifdef DVI_UNDERFLOW_COUNT_EN
        .underflow_count(p1_underflow_count),
`endif
        .dvi_reset_b(p1_reset_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, de_cnt, hs_cnt, vs_cnt, p1_hs_cnt, p1_vs_cnt, fs_cnt, overlap, lat_bad, data_bad;
        int first_de, first_hs, last_vs, black, de_win;
        logic prev_ready, seen_rdy;
        logic [10:0] fx, lx;
        logic [9:0]  fy, ly;

        // R=1F, G=10101, B=03
        pix_data = {5'h1F, 5'b10101, 5'h03};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_de", dvi_de, 0);
        chk("rst_h", dvi_h, 1);
        chk("rst_v", dvi_v, 1);
        chk("rst_data_b", dvi_data_b, 0);
        chk("rst_data_a", dvi_data_a, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_reset_b", dvi_reset_b, 0);
        chk("rst_p1_h", p1_h, 0);
        chk("rst_p1_v", p1_v, 0);
`ifdef DVI_UNDERFLOW_COUNT_EN
        chk("rst_ucount", underflow_count, 0);
`endif

        // Codec reset release
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (dvi_reset_b !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("reset_b_cycles", n, RC);
        @(posedge clk); #1;
        chk("first_frame_start", frame_start, 1);

        // One full frame with output index i = h + HT*v
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; p1_hs_cnt = 0; p1_vs_cnt = 0; fs_cnt = 0;
        overlap = 0; lat_bad = 0; data_bad = 0; first_de = -1; first_hs = -1; last_vs = -1;
        prev_ready = 1'b0; seen_rdy = 1'b0; fx = '0; fy = '0; lx = '0; ly = '0;
        for (int i = 0; i < HT * VT; i++) begin
            if (dvi_de) begin
                de_cnt++;
                if (first_de < 0) first_de = i;
                if (dvi_data_b !== 12'h7E0 || dvi_data_a !== 12'hA30) data_bad++;
            end else if (dvi_data_b !== 12'h0 || dvi_data_a !== 12'h0) begin
                data_bad++;
            end
            if (dvi_h == 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = i;
            end
            if (dvi_v == 1'b0) begin
                vs_cnt++;
                last_vs = i;
            end
            if (p1_h == 1'b1) p1_hs_cnt++;
            if (p1_v == 1'b1) p1_vs_cnt++;
            if (frame_start) fs_cnt++;
            if (int'(dvi_h == 1'b0) + int'(dvi_v == 1'b0) + int'(dvi_de) > 1) overlap++;
            if (i > 0 && dvi_de !== prev_ready) lat_bad++;
            if (pix_ready) begin
                if (!seen_rdy) begin
                    fx = pix_x; fy = pix_y; seen_rdy = 1'b1;
                end
                lx = pix_x; ly = pix_y;
            end
            prev_ready = pix_ready;
            @(posedge clk); #1;
        end
        chk("de_cycles", de_cnt, VV * HV);
        chk("hsync_cycles", hs_cnt, VV * HS);
        chk("vsync_cycles", vs_cnt, VS * HT);
        chk("p1_hsync_cycles", p1_hs_cnt, VV * HS);
        chk("p1_vsync_cycles", p1_vs_cnt, VS * HT);
        chk("first_de_index", first_de, (VS + VB) * HT + HS + HB);
        chk("first_hsync_index", first_hs, (VS + VB) * HT);
        chk("last_vsync_index", last_vs, VS * HT - 1);
        chk("frame_start_count", fs_cnt, 1);
        chk("hvde_overlap", overlap, 0);
        chk("de_latency", lat_bad, 0);
        chk("pixel_data", data_bad, 0);
        chk("first_pix_x", fx, 0);
        chk("first_pix_y", fy, 0);
        chk("last_pix_x", lx, HV - 1);
        chk("last_pix_y", ly, VV - 1);
        chk("frame_wrap_start", frame_start, 1);

        // Three starved pixels starting at column 2
        n = 0;
        while (!(pix_ready && pix_x == 11'd2) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_col2", int'(n < 200), 1);
        chk("underflow_before", underflow, 0);
        pix_valid = 1'b0;
        black = 0; de_win = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (j == 2) pix_valid = 1'b1;
            if (dvi_de) de_win++;
            if (dvi_de && dvi_data_b === 12'h0 && dvi_data_a === 12'h0) black++;
        end
        chk("underflow_set", underflow, 1);
        chk("black_pixels", black, 3);
        chk("de_during_starve", de_win, 6);
`ifdef DVI_UNDERFLOW_COUNT_EN
        chk("underflow_count", underflow_count, 3);
`endif
        underflow_clr = 1'b1;
        @(posedge clk); #1;
        underflow_clr = 1'b0;
        chk("underflow_cleared", underflow, 0);
`ifdef DVI_UNDERFLOW_COUNT_EN
        chk("underflow_count_cleared", underflow_count, 0);
`endif

        // Clear and fresh starvation in the same cycle: set wins
        n = 0;
        while (!pix_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_ready", int'(n < 200), 1);
        pix_valid = 1'b0;
        underflow_clr = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b1;
        underflow_clr = 1'b0;
        chk("set_wins", underflow, 1);
`ifdef DVI_UNDERFLOW_COUNT_EN
        chk("set_wins_count", underflow_count, 1);
`endif

        // Enable drop and re-entry at frame origin
        en = 1'b0;
        #1;
        chk("en_low_ready", pix_ready, 0);
        @(posedge clk); #1;
        chk("en_low_de", dvi_de, 0);
        chk("en_low_h", dvi_h, 1);
        chk("en_low_v", dvi_v, 1);
        chk("en_low_p1_v", p1_v, 0);
        @(posedge clk); #1;
        chk("en_low_fs", frame_start, 0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("en_rise_fs", frame_start, 1);

        // Asynchronous reset in the middle of an active line
        n = 0;
        while (!dvi_de && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_de", int'(n < 400), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_de", dvi_de, 0);
        chk("async_h", dvi_h, 1);
        chk("async_v", dvi_v, 1);
        chk("async_data_b", dvi_data_b, 0);
        chk("async_underflow", underflow, 0);
        chk("async_reset_b", dvi_reset_b, 0);
        chk("async_ready", pix_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (dvi_reset_b !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("rerelease_cycles", n, RC);
        @(posedge clk); #1;
        chk("restart_fs", frame_start, 1);
        chk("restart_v", dvi_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
